// File: rtl/uart_tx_mmio_if.sv
// Data-path memory bus as seen by the MMIO UART.
// master: data path drives we/address/data; slave: UART returns read data and hit.
interface uart_tx_mmio_if #(
  parameter int WIDTH = 32
);
  logic             we_i;
  logic [WIDTH-1:0] address_i;
  logic [WIDTH-1:0] write_data_i;
  logic [WIDTH-1:0] read_data_o;
  logic             hit_o;

  modport master (
    output we_i,
    output address_i,
    output write_data_i,
    input  read_data_o,
    input  hit_o
  );

  modport slave (
    input  we_i,
    input  address_i,
    input  write_data_i,
    output read_data_o,
    output hit_o
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Ports: clk, reset (async active-low), bus (slave), tx_o, busy_o, fifo_full_o.
module uart_tx_mmio #(
  parameter int               WIDTH       = 32,
  parameter int               BAUD_DIV    = 434,
  parameter int               FIFO_DEPTH  = 4,
  parameter logic [WIDTH-1:0] TX_ADDR     = 32'h1001_0024,
  parameter logic [WIDTH-1:0] STATUS_ADDR = 32'h1001_0028
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx_o,
  output logic           busy_o,
  output logic           fifo_full_o
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;

  logic tx_sel;
  logic st_sel;
  logic push_req;
  logic pop;
  logic accept;
  logic clr;
  logic bit_end;
  logic unused_hi;

  assign tx_sel   = (bus.address_i == TX_ADDR);
  assign st_sel   = (bus.address_i == STATUS_ADDR);
  assign push_req = bus.we_i & tx_sel;
  assign pop      = (state == IDLE) & (count != '0);
  // A full FIFO still takes a byte when the head leaves this cycle.
  assign accept   = push_req & (~fifo_full_o | pop);
  assign clr      = bus.we_i & st_sel & bus.write_data_i[2];
  assign bit_end  = (baud == BAUD_LAST);

  assign busy_o      = (state != IDLE) | (count != '0);
  assign fifo_full_o = (count == DEPTH_C);
  assign bus.hit_o   = tx_sel | st_sel;
  assign unused_hi   = ^bus.write_data_i[WIDTH-1:8];

  always_comb begin
    bus.read_data_o = '0;
    unique case (1'b1)
      st_sel: bus.read_data_o =
        WIDTH'({overflow, fifo_full_o, busy_o});
      tx_sel: bus.read_data_o = WIDTH'(count);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.write_data_i[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Set has priority over a coincident clear.
      if (push_req & ~accept) overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  // tx_o reflects the state one clock late, so START goes
  // low on the edge after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          tx_o <= 1'b0;
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          tx_o <= shift[0];
          if (bit_end) begin
            baud    <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          tx_o <= 1'b1;
          if (bit_end) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (BAUD_DIV=4, FIFO_DEPTH=4).
// Frames are rebuilt from bytes and compared clock by clock on tx_o.
module tb_uart_tx_mmio;

  localparam int BD = 4;
  localparam int FL = 10 * BD;
  localparam logic [31:0] TXA = 32'h1001_0024;
  localparam logic [31:0] STA = 32'h1001_0028;

  logic clk;
  logic rst_n;
  logic tx_o;
  logic busy_o;
  logic fifo_full_o;

  int checks;
  int errors;

  uart_tx_mmio_if #(.WIDTH(32)) bus ();

  uart_tx_mmio #(
    .WIDTH(32),
    .BAUD_DIV(BD),
    .FIFO_DEPTH(4),
    .TX_ADDR(TXA),
    .STATUS_ADDR(STA)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus),
    .tx_o(tx_o),
    .busy_o(busy_o),
    .fifo_full_o(fifo_full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(
    input logic [31:0] a,
    input logic [31:0] d
  );
    bus.address_i    = a;
    bus.write_data_i = d;
    bus.we_i         = 1'b1;
    tick();
    bus.we_i         = 1'b0;
    bus.address_i    = '0;
    bus.write_data_i = '0;
  endtask

  task automatic read_reg(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] exp
  );
    bus.address_i = a;
    #1;
    check(tag, bus.read_data_o, exp);
  endtask

  // Wait for a start bit, then capture FL samples of the line
  // and compare with the ideal 8N1 waveform of byte b.
  // gap: clocks from call until the line falls (-1: any).
  task automatic rx_frame(
    input logic [7:0] b,
    input int         gap,
    input string      tag
  );
    int w;
    int n;
    logic [63:0] obs;
    logic [63:0] exp;
    w = 0;
    while (tx_o !== 1'b0 && w < 200) begin
      tick();
      w++;
    end
    if (tx_o !== 1'b0) begin
      check({tag, "_timeout"}, tx_o, 0);
      return;
    end
    if (gap >= 0) check({tag, "_gap"}, w, gap);
    obs = '0;
    exp = '0;
    for (int s = 0; s < FL; s++) begin
      n = s / BD;
      if (n == 0) exp[s] = 1'b0;
      else if (n == 9) exp[s] = 1'b1;
      else exp[s] = b[n-1];
    end
    obs[0] = tx_o;
    for (int s = 1; s < FL; s++) begin
      tick();
      obs[s] = tx_o;
    end
    check(tag, obs, exp);
  endtask

  initial begin
    logic [31:0] ra [8];
    logic [31:0] rd [8];
    logic [7:0]  q [$];
    int          n;
    int          ntx;
    logic        low_seen;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.we_i = 1'b0;
    bus.address_i = '0;
    bus.write_data_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_full", fifo_full_o, 0);
    rst_n = 1'b1;
    tick();
    read_reg("rst_status", STA, 0);
    check("rst_hit", bus.hit_o, 1);
    bus.address_i = '0;
    tick();

    // Single byte; line falls 2 clocks after the store edge.
    fork
      do_store(TXA, 32'hFFFF_FFA5);
      begin
        rx_frame(8'hA5, 3, "a5");
        tick();
        check("a5_busy", busy_o, 0);
      end
    join

    // Six back-to-back stores: one popped, four queued, one lost.
    fork
      begin
        for (int i = 1; i <= 6; i++) do_store(TXA, i);
        read_reg("burst_status", STA, 7);
        check("burst_full", fifo_full_o, 1);
        read_reg("burst_count", TXA, 4);
        bus.address_i = '0;
      end
      begin
        rx_frame(8'h01, 3, "b1");
        for (int i = 2; i <= 5; i++) rx_frame(i, 2, "bn");
        tick();
        check("burst_busy", busy_o, 0);
      end
    join
    tick();
    read_reg("ovf_sticky", STA, 4);
    tick();
    do_store(STA, 32'h4);
    read_reg("ovf_clear", STA, 0);
    read_reg("miss_data", 32'h1001_0000, 0);
    check("miss_hit", bus.hit_o, 0);
    bus.address_i = '0;
    tick();

    // Full FIFO with a store landing on the IDLE pop edge.
    fork
      begin
        for (int i = 0; i < 5; i++) do_store(TXA, 8'h10 + i);
        repeat (FL - 3) tick();
        do_store(TXA, 32'h15);
        read_reg("fp_count", TXA, 4);
        check("fp_full", fifo_full_o, 1);
        read_reg("fp_status", STA, 3);
        bus.address_i = '0;
      end
      begin
        rx_frame(8'h10, 3, "fp0");
        for (int i = 1; i <= 5; i++) rx_frame(8'h10 + i, 2, "fpn");
        tick();
        check("fp_busy", busy_o, 0);
      end
    join
    tick();

    // Random bursts mixing TX stores with writes elsewhere.
    repeat (5) begin
      n = $urandom_range(1, 8);
      ntx = 0;
      q.delete();
      for (int i = 0; i < n; i++) begin
        rd[i] = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          ra[i] = TXA;
          if (ntx < 5) q.push_back(rd[i][7:0]);
          ntx++;
        end else begin
          ra[i] = 32'h1001_0000 + 4 * $urandom_range(0, 8);
        end
      end
      fork
        for (int i = 0; i < n; i++) do_store(ra[i], rd[i]);
        for (int k = 0; k < q.size(); k++)
          rx_frame(q[k], (k == 0) ? -1 : 2, "rnd");
      join
      repeat (2) tick();
      check("rnd_busy", busy_o, 0);
      read_reg("rnd_status", STA, (ntx > 5) ? 4 : 0);
      tick();
      do_store(STA, $urandom | 32'h4);
      read_reg("rnd_clear", STA, 0);
      bus.address_i = '0;
      tick();
    end

    // Reset in the middle of data bit 3 with two bytes queued.
    do_store(TXA, 32'h37);
    do_store(TXA, 32'hC3);
    do_store(TXA, 32'h5A);
    check("mr_start", tx_o, 0);
    repeat (18) tick();
    check("mr_bit3", tx_o, 0);
    check("mr_busy_pre", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("mr_tx", tx_o, 1);
    check("mr_busy", busy_o, 0);
    check("mr_full", fifo_full_o, 0);
    #2;
    rst_n = 1'b1;
    tick();
    low_seen = 1'b0;
    repeat (100) begin
      tick();
      if (tx_o !== 1'b1) low_seen = 1'b1;
    end
    check("mr_quiet", low_seen, 0);
    read_reg("mr_status", STA, 0);
    read_reg("mr_count", TXA, 0);
    bus.address_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
